commit_trace_buffer: RTL
========================

# commit_trace_buffer

Hardware commit-trace recorder sitting directly downstream of the `cpu` core, between its retire signals and the simulation/debug consumer. Each clock it classifies the retiring instruction as REG, LOAD, STORE, HALT or OTHER and stamps it with a sequential instruction number. It pushes the resulting record into a FIFO and drains records over a valid/ready handshake. After HALT it stops capturing and raises `done` once the FIFO empties.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `INUM_W`, 32: instruction-number counter width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cap_en`  in  1  capture enable; driven by core reset-release, e.g. `~rst_n` of core inverted.
- `pc`  in  16  PC of retiring instruction.
- `reg_write`  in  1  register file written this cycle.
- `write_reg`  in  4  destination register.
- `write_data`  in  16  register write data.
- `mem_read`  in  1  load in progress.
- `mem_write`  in  1  store committed this cycle.
- `mem_addr`  in  16  memory address.
- `mem_wdata`  in  16  store data.
- `hlt`  in  1  HALT retiring.
- `out_valid`  out  1  record available.
- `out_ready`  in  1  consumer accepts record.
- `out_rec`  out  `trace_rec_t`  head record: kind, inum, pc, reg, data, addr.
- `overflow`  out  1  sticky; at least one record dropped.
- `drop_cnt`  out  16  dropped-record count, saturating at 0xFFFF.
- `done`  out  1  HALT captured and FIFO empty.

## Operation
- Classification priority, evaluated each cycle with `cap_en=1`, not halted:
  - `reg_write & mem_read` → LOAD (reg, data, addr)
  - `reg_write` → REG (reg, data)
  - `hlt` → HALT
  - `mem_write` → STORE (addr, data=`mem_wdata`)
  - otherwise → OTHER (pc only)
- Exactly one record is generated per enabled cycle. Unused fields are zero.
- `inum` is taken from a counter starting at 0. The counter increments for every generated record, including dropped ones, so gaps reveal drops.
- HALT record: sets the `halted` state. Subsequent cycles generate nothing until reset.
- States:
  - CAPTURE: `cap_en` gates record generation; HALT moves to DRAIN.
  - DRAIN: `done = (fifo empty)`.
  - No exit except `rst`.
- FIFO full with no pop in the same cycle: the record is dropped, `overflow` is set, and `drop_cnt` increments.
- Full FIFO with a simultaneous pop (`out_valid & out_ready`): the push succeeds.
- Empty FIFO with a simultaneous push: `out_valid` rises the next cycle. There is no bypass.
- Dropped HALT: the `halted` state is still set and `done` still asserts after the drain.
- Pointers are `log2(DEPTH)+1` bits; wrap is natural modulo. Full/empty are distinguished by the MSB.

## Timing
- Reset values:
  - `out_valid=0`, `out_rec=0`, `overflow=0`, `drop_cnt=0`, `done=0`
  - inum counter 0; state CAPTURE.
- Record latency is 1 cycle: inputs are sampled at edge N, and the record is visible at `out_rec` after edge N, when the FIFO was empty.
- Handshake:
  - `out_rec` is stable while `out_valid & ~out_ready`.
  - A pop occurs on an edge with both signals high.
  - `out_valid` never deasserts without a pop.
- Throughput is one record per cycle in and one per cycle out.
- `done` asserts on the edge after the last pop following HALT, or on the edge after HALT capture if the FIFO was already empty after that push drains.
- Asserting `rst` mid-operation clears the FIFO, counters and state immediately (asynchronous). Capture resumes on the first edge with `rst=0` and `cap_en=1`.

## Configuration
- `TRACE_CYCLE_STAMP_EN`:
  - Defined: a 32-bit free-running cycle counter is added. It resets to 0 and increments every edge with `rst=0`. `trace_rec_t` gains a `cycle` field carrying the capture-cycle value.
  - Undefined: there is no counter, no field, and the record is 32 bits narrower.
  - All other behaviour is identical in both cases.

## Structure
- Package `trace_pkg` holds:
  - `trace_kind_e` (REG=0, LOAD=1, STORE=2, HALT=3, OTHER=4, 3 bits)
  - `trace_rec_t` packed struct, with the conditional `cycle` field under the macro
  - constant `TRACE_DROP_MAX=16'hFFFF`
- Sub-module `trace_fifo`: generic synchronous FIFO parameterised on `DEPTH` and data type. It provides `push`/`pop`/`full`/`empty`/`head`.
- Top level holds the classifier, counters and the CAPTURE/DRAIN FSM.

## Test plan
- Reset, then `cap_en=1`, `reg_write=1`, `write_reg=3`, `write_data=0x1234`, `pc=0x0002` for one cycle, `out_ready=1` → one REG record with inum 0, reg 3, data 0x1234, `out_valid` pulse one cycle later.
- Consecutive LOAD (addr 0x0040), STORE (addr 0x0042, data 0xBEEF), OTHER → kinds 1, 2, 4 with inums 0, 1, 2 in order.
- `out_ready=0`, DEPTH+3 REG cycles → FIFO holds inums 0..15, `overflow=1`, `drop_cnt=3`. Next captured inum is 19.
- Full FIFO, push and pop in the same cycle → no drop, occupancy stays at DEPTH.
- HALT at `pc=0x0010` with 2 records queued, then draining → HALT record last, `done=1` after the third pop. Further `reg_write` cycles produce no records.
- `rst` asserted mid-drain → `out_valid`, `done`, `overflow` drop to 0 immediately. Next record after release has inum 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the commit trace recorder.
// TRACE_CYCLE_STAMP_EN adds a 32-bit capture-cycle field to every record.
package trace_pkg;

    typedef enum logic [2:0] {
        REG   = 3'd0,
        LOAD  = 3'd1,
        STORE = 3'd2,
        HALT  = 3'd3,
        OTHER = 3'd4
    } trace_kind_e;

    localparam logic [15:0] TRACE_DROP_MAX = 16'hFFFF;

    typedef struct packed {
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0] cycle;
`endif
        trace_kind_e kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [3:0]  reg_id;
        logic [15:0] data;
        logic [15:0] addr;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO; pointers carry one extra bit so full and empty
// are told apart by the MSB. A push into a full FIFO succeeds only with a pop.
module trace_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count   = wr_q - rd_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign wr_d    = wr_q + (AW+1)'(do_push);
    assign rd_d    = rd_q + (AW+1)'(do_pop);
    assign head    = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Classifies each retiring instruction, numbers it and queues it for a
// valid/ready consumer. Optional cycle stamp under TRACE_CYCLE_STAMP_EN.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int INUM_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic [15:0] pc,
    input  logic        reg_write,
    input  logic [3:0]  write_reg,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        hlt,
    output logic        out_valid,
    input  logic        out_ready,
    output trace_rec_t  out_rec,
    output logic        overflow,
    output logic [15:0] drop_cnt,
    output logic        done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CAPTURE = 1'b0, DRAIN = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [INUM_W-1:0]   inum_q;
    logic                overflow_q;
    logic [15:0]         drop_cnt_q;
    logic                done_q;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]         cycle_q;
`endif

    trace_rec_t  rec_d, head;
    logic        gen, full, empty, pop_ok, accept, drop;
    logic [AW:0] count, occ_d;

    assign gen    = cap_en && (state_q == CAPTURE);
    assign pop_ok = out_ready & ~empty;
    assign accept = gen & (~full | pop_ok);
    assign drop   = gen & full & ~pop_ok;
    assign occ_d  = count + (AW+1)'(accept) - (AW+1)'(pop_ok);

    always_comb begin
        rec_d      = '0;
        rec_d.inum = 32'(inum_q);
        rec_d.pc   = pc;
`ifdef TRACE_CYCLE_STAMP_EN
        rec_d.cycle = cycle_q;
`endif
        if (reg_write && mem_read) begin
            rec_d.kind   = LOAD;
            rec_d.reg_id = write_reg;
            rec_d.data   = write_data;
            rec_d.addr   = mem_addr;
        end else if (reg_write) begin
            rec_d.kind   = REG;
            rec_d.reg_id = write_reg;
            rec_d.data   = write_data;
        end else if (hlt) begin
            rec_d.kind   = HALT;
        end else if (mem_write) begin
            rec_d.kind   = STORE;
            rec_d.addr   = mem_addr;
            rec_d.data   = mem_wdata;
        end else begin
            rec_d.kind   = OTHER;
        end
    end

    // A dropped HALT still ends capture.
    assign state_d = (gen && rec_d.kind == HALT) ? DRAIN : state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CAPTURE;
            inum_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            done_q     <= 1'b0;
`ifdef TRACE_CYCLE_STAMP_EN
            cycle_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DRAIN) && (occ_d == '0);
            if (gen) inum_q <= inum_q + 1'b1;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != TRACE_DROP_MAX) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
`ifdef TRACE_CYCLE_STAMP_EN
            cycle_q <= cycle_q + 32'd1;
`endif
        end
    end

    trace_fifo #(.DEPTH(DEPTH), .T(trace_rec_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gen),
        .pop   (out_ready),
        .din   (rec_d),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_valid = ~empty;
    assign out_rec   = empty ? '0 : head;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign done      = done_q;

endmodule
